// File: rtl/decode_exec_pipe.sv
// decode_exec_pipe: decode->execute pipeline register with a two-entry
// skid buffer, flush-to-bubble, and a saturating stall-cycle counter.
module decode_exec_pipe #(
  parameter int               XLEN     = 32,
  parameter int               REG_AW   = 5,
  parameter int               ALU_CW   = 4,
  parameter int               MTR_W    = 2,
  parameter int               CNT_W    = 16,
  parameter logic [XLEN-1:0]  NOP_INSN = XLEN'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_in,
  input  logic              store_in,
  input  logic              next_sel_in,
  input  logic              branch_result_in,
  input  logic              reg_write_in,
  input  logic [REG_AW-1:0] rs1_in,
  input  logic [REG_AW-1:0] rs2_in,
  input  logic [ALU_CW-1:0] alu_control_in,
  input  logic [MTR_W-1:0]  mem_to_reg_in,
  input  logic [XLEN-1:0]   opa_mux_in,
  input  logic [XLEN-1:0]   opb_mux_in,
  input  logic [XLEN-1:0]   opb_data_in,
  input  logic [XLEN-1:0]   pre_address_in,
  input  logic [XLEN-1:0]   instruction_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              load,
  output logic              store,
  output logic              next_sel,
  output logic              branch_result,
  output logic              reg_write_out,
  output logic [REG_AW-1:0] rs1_out,
  output logic [REG_AW-1:0] rs2_out,
  output logic [ALU_CW-1:0] alu_control,
  output logic [MTR_W-1:0]  mem_to_reg,
  output logic [XLEN-1:0]   opa_mux_out,
  output logic [XLEN-1:0]   opb_mux_out,
  output logic [XLEN-1:0]   opb_data_out,
  output logic [XLEN-1:0]   pre_address_out,
  output logic [XLEN-1:0]   instruction_out,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              load;
    logic              store;
    logic              next_sel;
    logic              branch_result;
    logic              reg_write;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [ALU_CW-1:0] alu_control;
    logic [MTR_W-1:0]  mem_to_reg;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   opb_data;
    logic [XLEN-1:0]   pre_address;
    logic [XLEN-1:0]   instruction;
  } payload_t;

  payload_t         r_main;
  payload_t         r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  payload_t w_in;
  logic     w_accept;
  logic     w_consume;
  logic     w_stall;
  logic     w_main_valid_d;
  logic     w_skid_valid_d;
  logic     w_main_from_in;
  logic     w_main_from_skid;
  logic     w_skid_from_in;

  assign w_in = '{
    load:          load_in,
    store:         store_in,
    next_sel:      next_sel_in,
    branch_result: branch_result_in,
    reg_write:     reg_write_in,
    rs1:           rs1_in,
    rs2:           rs2_in,
    alu_control:   alu_control_in,
    mem_to_reg:    mem_to_reg_in,
    opa:           opa_mux_in,
    opb:           opb_mux_in,
    opb_data:      opb_data_in,
    pre_address:   pre_address_in,
    instruction:   instruction_in
  };

  // in_ready comes straight from a flop so it never depends on out_ready
  assign in_ready  = ~r_skid_valid;
  assign w_accept  = in_valid & ~r_skid_valid;
  assign w_consume = r_main_valid & out_ready;
  assign w_stall   = r_main_valid & ~out_ready;

  // next-state steering for the main/skid entries
  always_comb begin
    w_main_valid_d   = r_main_valid;
    w_skid_valid_d   = r_skid_valid;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    if (flush) begin
      w_main_valid_d = 1'b0;
      w_skid_valid_d = 1'b0;
    end else if (!r_main_valid) begin
      if (w_accept) begin
        w_main_valid_d = 1'b1;
        w_main_from_in = 1'b1;
      end
    end else if (w_consume) begin
      if (r_skid_valid) begin
        w_main_from_skid = 1'b1;
        w_skid_valid_d   = 1'b0;
      end else if (w_accept) begin
        w_main_from_in = 1'b1;
      end else begin
        w_main_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_from_in = 1'b1;
      w_skid_valid_d = 1'b1;
    end
  end

  // entry valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_d;
      r_skid_valid <= w_skid_valid_d;
    end
  end

  // payload registers; left untouched by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_from_in)
        r_main <= w_in;
      else if (w_main_from_skid)
        r_main <= r_skid;
      if (w_skid_from_in)
        r_skid <= w_in;
    end
  end

  // saturating count of cycles the execute side held off a valid beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign out_valid       = r_main_valid;
  assign load            = r_main.load          & r_main_valid;
  assign store           = r_main.store         & r_main_valid;
  assign next_sel        = r_main.next_sel      & r_main_valid;
  assign branch_result   = r_main.branch_result & r_main_valid;
  assign reg_write_out   = r_main.reg_write     & r_main_valid;
  assign rs1_out         = r_main.rs1;
  assign rs2_out         = r_main.rs2;
  assign alu_control     = r_main.alu_control;
  assign mem_to_reg      = r_main.mem_to_reg;
  assign opa_mux_out     = r_main.opa;
  assign opb_mux_out     = r_main.opb;
  assign opb_data_out    = r_main.opb_data;
  assign pre_address_out = r_main.pre_address;
  assign instruction_out = r_main_valid ? r_main.instruction : NOP_INSN;
  assign stall_count     = r_stall_cnt;

endmodule

// File: doc/decode_exec_pipe.md
# decode_exec_pipe

Parametrised decode→execute pipeline register for the RV32I pipeline. It carries the decoded control bits and operands from the decode stage to the execute stage. It adds what the plain register stage lacks: asynchronous reset, a valid/ready handshake with a two-entry skid buffer for full-throughput backpressure, a flush that turns in-flight entries into bubbles, and a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- XLEN, 32, width of operand, PC and instruction fields
- REG_AW, 5, register-file address width (rs1/rs2)
- ALU_CW, 4, ALU control width
- MTR_W, 2, mem_to_reg select width
- CNT_W, 16, stall counter width
- NOP_INSN, 32'h00000013, instruction presented while out_valid=0

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all held entries and the incoming beat
- in_valid  in  1  decode stage presents a beat
- in_ready  out  1  stage can accept a beat
- load_in, store_in, next_sel_in, branch_result_in, reg_write_in  in  1 each  control bits
- rs1_in, rs2_in  in  REG_AW  source register indices
- alu_control_in  in  ALU_CW;  mem_to_reg_in  in  MTR_W
- opa_mux_in, opb_mux_in, opb_data_in, pre_address_in, instruction_in  in  XLEN each
- out_valid  out  1  execute-side beat valid
- out_ready  in  1  execute stage consumes the beat
- load, store, next_sel, branch_result, reg_write_out  out  1 each  control bits, forced 0 when out_valid=0
- rs1_out, rs2_out, alu_control, mem_to_reg, opa_mux_out, opb_mux_out, opb_data_out, pre_address_out  out  field widths as inputs
- instruction_out  out  XLEN  held instruction, NOP_INSN when out_valid=0
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main entry (drives outputs) and skid entry, each holding the full payload plus a valid bit.
- in_ready is registered: in_ready = !skid_valid.
- Accept = in_valid & in_ready; Consume = out_valid & out_ready; out_valid = main_valid.
- Next-state rules, when flush=0:
  - main empty: an accepted beat loads main.
  - main full and Consume: main loads the skid entry if skid is valid (skid then empties), else the accepted beat, else main empties.
  - main full and no Consume: an accepted beat loads skid. In_ready then drops the next cycle.
  - Skid full implies no Accept, so at most 2 beats are ever held.
- Flush, highest priority: main_valid and skid_valid clear on the next edge. The incoming beat is dropped even if Accept. A Consume in the flush cycle still counts as delivered. Payload registers are not cleared.
- Output gating: the 5 control outputs are the stored bit AND out_valid. instruction_out = out_valid ? stored : NOP_INSN. Other data outputs show the stored payload unconditionally.
- stall_count increments when out_valid & !out_ready and holds at all-ones. Flush does not clear it; only rst does.
- Beats leave in the order accepted; payload is never modified.

## Timing
- Reset (async assert, sync release): out_valid=0, skid_valid=0, in_ready=1, all payload registers 0, stall_count=0.
  - Gated outputs therefore read 0 and instruction_out reads NOP_INSN during and after reset.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N.
- Throughput: 1 beat/cycle with out_ready held high; no bubbles inserted.
- Backpressure: in_ready falls one cycle after the first beat captured while stalled. It rises one cycle after the skid drains.
- rst asserted mid-transfer: all held beats are lost, with no partial state.
- flush and rst together: rst dominates; the result is identical.
- Flush with skid full: both entries are dropped, and in_ready=1 on the next cycle.

## Test plan
- Reset: assert rst mid-cycle with 2 beats held -> immediately out_valid=0, in_ready=1, load/store/reg_write_out=0, instruction_out=0x00000013, stall_count=0.
- Streaming: out_ready=1, 8 back-to-back beats with instruction_in=0x100+i -> outputs 0x100..0x107 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1.
- Backpressure: out_ready=0 for 5 cycles while feeding beats A,B,C -> A held on output, B in skid, in_ready=0 from cycle 2, C not accepted until released; after out_ready=1 the output order is A,B,C with no loss; stall_count=5.
- Flush: 2 beats held plus in_valid=1 with flush=1 -> next cycle out_valid=0, reg_write_out=0, instruction_out=NOP, in_ready=1; the flushed beats never reappear.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_count reaches 15 and holds.
- Gating: a beat with reg_write_in=1 and store_in=1 is consumed, then idle -> reg_write_out and store drop to 0 the cycle after the Consume, while opa_mux_out still shows the last value.
